rbe_bitplane_accum: RTL and testbench

- Sits directly downstream of the RBE scale stage.
- Consumes the stream of shifted (bit-plane-weighted) partial sums that the scale stage produces, one beat per bit-plane.
- Accumulates a programmable number of beats into one wide result, with optional two's-complement handling of the MSB plane.
- Emits one accumulated value per group on an output stream towards the normalization/quantization stage.

---
 rtl/rbe_bitplane_accum.sv | 84 ++++++++
 tb/tb_rbe_bitplane_accum.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rbe_bitplane_accum.sv
// rbe_bitplane_accum: accumulates n_acc+1 bit-plane-weighted beats into one wide result,
// optionally subtracting the last (MSB) plane for two's-complement operands.
module rbe_bitplane_accum #(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 24,
  parameter int CNT_WIDTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   data_i_valid,
  output logic                   data_i_ready,
  input  logic [IN_WIDTH-1:0]    data_i_data,
  input  logic [IN_WIDTH/8-1:0]  data_i_strb,
  output logic                   data_o_valid,
  input  logic                   data_o_ready,
  output logic [ACC_WIDTH-1:0]   data_o_data,
  output logic [ACC_WIDTH/8-1:0] data_o_strb,
  input  logic [CNT_WIDTH+1:0]   ctrl_i,
  output logic [CNT_WIDTH+1:0]   flags_o
);
  typedef enum logic {ACCUM = 1'b0, OUTPUT = 1'b1} state_t;
  state_t               r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_n_lat;
  logic                 r_sgn_lat;
  logic                 w_clear;
  logic [CNT_WIDTH-1:0] w_n_acc;
  logic                 w_sgn_msb;
  logic                 w_in_hs;
  logic                 w_out_hs;
  logic                 w_first;
  logic [CNT_WIDTH-1:0] w_n;
  logic                 w_s;
  logic                 w_last;
  logic [ACC_WIDTH-1:0] w_ext;
  logic [ACC_WIDTH-1:0] w_base;
  logic [ACC_WIDTH-1:0] w_sum;
  logic                 w_unused;
  // ctrl_i = {clear, n_acc, signed_msb}; flags_o = {state, cnt, busy}
  assign w_clear   = ctrl_i[CNT_WIDTH+1];
  assign w_n_acc   = ctrl_i[CNT_WIDTH:1];
  assign w_sgn_msb = ctrl_i[0];
  assign w_unused  = ^data_i_strb;
  assign data_o_valid = r_state == OUTPUT;
  assign data_o_data  = r_acc;
  assign data_o_strb  = '1;
  assign data_i_ready = w_clear | (r_state == ACCUM) | data_o_ready;
  assign flags_o      = {r_state == OUTPUT, r_cnt, (r_cnt != '0) | (r_state == OUTPUT)};
  assign w_in_hs  = data_i_valid & data_i_ready & ~w_clear;
  assign w_out_hs = (r_state == OUTPUT) & data_o_ready;
  // cnt is always zero in OUTPUT, so an input beat there starts a new group
  assign w_first = r_cnt == '0;
  assign w_n     = w_first ? w_n_acc : r_n_lat;
  assign w_s     = w_first ? w_sgn_msb : r_sgn_lat;
  assign w_last  = r_cnt == w_n;
  assign w_ext   = {{(ACC_WIDTH-IN_WIDTH){1'b0}}, data_i_data};
  assign w_base  = w_first ? '0 : r_acc;
  assign w_sum   = (w_last & w_s) ? w_base - w_ext : w_base + w_ext;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ACCUM;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_n_lat   <= '0;
      r_sgn_lat <= 1'b0;
    end else if (w_clear) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (w_in_hs) begin
      if (w_first) begin
        r_n_lat   <= w_n_acc;
        r_sgn_lat <= w_sgn_msb;
      end
      r_acc   <= w_sum;
      r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
      r_state <= w_last ? OUTPUT : ACCUM;
    end else if (w_out_hs) begin
      r_acc   <= '0;
      r_state <= ACCUM;
    end
  end
endmodule

// File: tb/tb_rbe_bitplane_accum.sv
// tb_rbe_bitplane_accum: scoreboard bench; expected results come from plain group arithmetic.
module tb_rbe_bitplane_accum;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        data_i_valid = 1'b0;
  logic        data_i_ready;
  logic [15:0] data_i_data = '0;
  logic [1:0]  data_i_strb = '0;
  logic        data_o_valid;
  logic        data_o_ready;
  logic [23:0] data_o_data;
  logic [2:0]  data_o_strb;
  logic [5:0]  ctrl_i = '0;
  logic [5:0]  flags_o;
  logic        sink_rand = 1'b0;
  logic        sink_force = 1'b1;
  logic        rand_rdy = 1'b1;
  logic [15:0] bv [16];
  logic [23:0] q [$];
  logic        prev_stall = 1'b0;
  logic [23:0] held = '0;
  int          checks = 0;
  int          failures = 0;
  int          w;

  rbe_bitplane_accum dut (
    .clk_i(clk), .rst_i(rst_i),
    .data_i_valid(data_i_valid), .data_i_ready(data_i_ready),
    .data_i_data(data_i_data), .data_i_strb(data_i_strb),
    .data_o_valid(data_o_valid), .data_o_ready(data_o_ready),
    .data_o_data(data_o_data), .data_o_strb(data_o_strb),
    .ctrl_i(ctrl_i), .flags_o(flags_o)
  );

  always #5 clk = ~clk;
  assign data_o_ready = sink_rand ? rand_rdy : sink_force;
  always @(negedge clk) rand_rdy <= ($urandom_range(0, 3) != 0);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (rst_i) prev_stall = 1'b0;
    else begin
      if (prev_stall && data_o_valid) chk("hold", data_o_data, held);
      if (data_o_valid && !data_o_ready && !ctrl_i[5]) chk("in_block", data_i_ready, 0);
      if (data_o_valid && data_o_ready) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_output: got %h expected none", data_o_data);
        end else chk("result", data_o_data, q.pop_front());
      end
      prev_stall = data_o_valid && !data_o_ready;
      held = data_o_data;
    end
  end

  // called at a falling edge; returns at the falling edge after the beat is taken
  task automatic send(input logic [15:0] d, output int waits);
    data_i_valid = 1'b1;
    data_i_data  = d;
    data_i_strb  = 2'($urandom);
    waits = 0;
    #1;
    while (!data_i_ready && waits < 500) begin
      @(negedge clk); #1; waits++;
    end
    if (!data_i_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout: got ready=0 expected ready=1");
    end
    @(negedge clk);
    data_i_valid = 1'b0;
  endtask

  task automatic group(input int n, input bit s, input bit gaps, input bit scramble, output int maxw);
    logic [23:0] e = '0;
    int wt;
    for (int i = 0; i <= n; i++) e = (i == n && s) ? e - 24'(bv[i]) : e + 24'(bv[i]);
    ctrl_i = {1'b0, 4'(n), s};
    maxw = 0;
    for (int i = 0; i <= n; i++) begin
      if (i == n) q.push_back(e);
      send(bv[i], wt);
      if (wt > maxw) maxw = wt;
      if (i == 0 && scramble) ctrl_i = {1'b0, 4'($urandom), 1'($urandom)};
      if (i == n) fork begin #1; chk("valid_lat", data_o_valid, 1); end join_none
      else if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_flags", flags_o, 0);
    chk("rst_valid", data_o_valid, 0);
    chk("rst_data", data_o_data, 0);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    bv[0] = 16'd1; bv[1] = 16'd2; bv[2] = 16'd4; bv[3] = 16'd8;
    group(3, 1'b0, 1'b0, 1'b1, w);
    chk("unsigned_waits", w, 0);
    group(3, 1'b1, 1'b0, 1'b1, w);
    chk("signed_waits", w, 0);
    for (int i = 5; i <= 7; i++) begin
      bv[0] = 16'(i);
      group(0, 1'b0, 1'b0, 1'b0, w);
      chk("b2b_waits", w, 0);
    end
    @(negedge clk);
    sink_force = 1'b0;
    bv[0] = 16'hFFFF; bv[1] = 16'hFFFF;
    group(1, 1'b0, 1'b0, 1'b0, w);
    ctrl_i = 6'b0_0000_0;
    data_i_valid = 1'b1;
    data_i_data  = 16'h0033;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_data", data_o_data, 24'h01FFFE);
      chk("stall_ready", data_i_ready, 0);
      @(negedge clk);
    end
    sink_force = 1'b1;
    q.push_back(24'h000033);
    #1;
    chk("resume_ready", data_i_ready, 1);
    @(negedge clk);
    data_i_valid = 1'b0;
    @(negedge clk);
    ctrl_i = {1'b0, 4'd3, 1'b0};
    send(16'd5, w);
    send(16'd6, w);
    ctrl_i = {1'b1, 4'd3, 1'b0};
    data_i_valid = 1'b1;
    data_i_data  = 16'd9;
    #1;
    chk("clear_ready", data_i_ready, 1);
    @(negedge clk);
    ctrl_i[5] = 1'b0;
    data_i_valid = 1'b0;
    #1;
    chk("clear_flags", flags_o, 0);
    chk("clear_valid", data_o_valid, 0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) bv[i] = 16'd3;
    group(3, 1'b0, 1'b0, 1'b0, w);
    @(negedge clk);
    ctrl_i = {1'b0, 4'd3, 1'b0};
    send(16'd1, w);
    send(16'd2, w);
    #3 rst_i = 1'b1;
    #1;
    chk("arst_mid_flags", flags_o, 0);
    chk("arst_mid_valid", data_o_valid, 0);
    @(negedge clk);
    rst_i = 1'b0;
    bv[0] = 16'd10; bv[1] = 16'd20;
    group(1, 1'b0, 1'b0, 1'b0, w);
    @(negedge clk);
    sink_force = 1'b0;
    bv[0] = 16'd7; bv[1] = 16'd7;
    group(1, 1'b0, 1'b0, 1'b0, w);
    @(negedge clk);
    #1;
    chk("stalled_valid", data_o_valid, 1);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_out_flags", flags_o, 0);
    chk("arst_out_valid", data_o_valid, 0);
    q.delete();
    @(negedge clk);
    rst_i = 1'b0;
    sink_force = 1'b1;
    bv[0] = 16'd4;
    group(0, 1'b0, 1'b0, 1'b0, w);
    sink_rand = 1'b1;
    for (int g = 0; g < 40; g++) begin
      for (int i = 0; i < 16; i++) bv[i] = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
      group($urandom_range(0, 15), 1'($urandom), 1'b1, 1'b1, w);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    @(negedge clk);
    sink_rand = 1'b0;
    sink_force = 1'b1;
    for (int t = 0; t < 100 && q.size() != 0; t++) @(negedge clk);
    chk("drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
